shift_deserializer: RTL
=======================

Name: shift_deserializer

Overview:
- Serial-to-parallel receiver; the receiving end of the universal shift register's serial output.
- Collects a framed serial stream (start bit, WIDTH data bits, stop bit), qualified by a bit strobe.
- Presents the assembled word in parallel with a one-cycle valid pulse and a framing-error pulse.
- Sits between a serial link (shift-register serial end or pin) and downstream parallel logic.

Parameters:
- WIDTH, 8, data bits per frame (2..32)
- IDLE_LEVEL, 1'b1, line level when idle; start bit is ~IDLE_LEVEL, stop bit is IDLE_LEVEL

Ports:
- clk  input  1  clock; all state updates on falling edge of clk
- reset  input  1  synchronous, active-low reset (sampled on the falling clk edge, asserted when 0)
- sin  input  1  serial data bit
- sen  input  1  bit strobe; sin is sampled only in cycles where sen=1
- dir  input  1  bit order: 0 = LSB first, 1 = MSB first; sampled with the start bit, held for the frame
- o  output  WIDTH  last correctly framed word
- o_valid  output  1  one-cycle pulse when o updates
- frame_err  output  1  one-cycle pulse on a bad stop bit
- busy  output  1  high from the accepted start bit until the frame ends

Behaviour:
- Reset (reset=0 at a falling clk edge):
  - state=IDLE; o=0, o_valid=0, frame_err=0, busy=0; shift reg=0, bit count=0.
  - Overrides every other input, including in mid-frame.
- States: IDLE, DATA, STOP (PARITY is added with the optional feature).
- IDLE:
  - sen=1 and sin=~IDLE_LEVEL: go to DATA, count=0, latch dir, busy=1.
  - sen=1 and sin=IDLE_LEVEL: ignored.
- DATA:
  - Each sen=1 shifts sin into the shift reg and increments count.
  - dir=0: shift right, sin enters at bit WIDTH-1, so the first bit received ends in bit 0.
  - dir=1: shift left, sin enters at bit 0, so the first bit received ends in bit WIDTH-1.
  - When count reaches WIDTH-1 and sen=1, the last bit is shifted in and the state goes to STOP.
- STOP, on sen=1:
  - sin=IDLE_LEVEL: o<=shift reg, o_valid=1 for the next cycle, go to IDLE.
  - Otherwise: frame_err=1 for the next cycle, o unchanged, go to IDLE.
  - busy drops in the same cycle the outputs pulse.
- Any cycle with sen=0: state, count and shift reg hold.
- Latency: o/o_valid are registered and appear on the falling edge that samples the stop bit. The earliest next start bit is accepted on the following sen.
- No back-pressure: o is overwritten by each new good frame. o_valid never stays high longer than one cycle.
- dir changes mid-frame have no effect.
- o_valid and frame_err are mutually exclusive.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN
- Defined:
  - A PARITY state follows DATA and takes one extra sen-qualified bit, compared against even parity of the data.
  - On mismatch with a good stop bit: frame_err pulses, o is not updated, o_valid stays 0.
  - On match: normal STOP handling.
- Undefined: no PARITY state; frame is start + WIDTH + stop.

Decomposition:
- Package shift_pkg:
  - state enum (IDLE, DATA, STOP, PARITY)
  - DIR_LSB_FIRST=0, DIR_MSB_FIRST=1
  - default WIDTH constant
  - count width function clog2(WIDTH)
- One sub-module: shift_bit_counter — enabled up-counter with synchronous clear and terminal-count flag at WIDTH-1; reused by the future serializer.

Test Plan:
- Reset=0 for 2 cycles with random sin/sen -> o=0x00, o_valid=0, frame_err=0, busy=0.
- dir=0, frame 0, bits 1,0,1,0,0,1,0,1 (LSB first), stop 1, one bit per cycle -> o=0xA5, o_valid pulse exactly 1 cycle, busy high for 9 cycles.
- dir=1, same bit sequence interleaved with random sen=0 gaps -> o=0xA5 after 10 strobes; gaps add no bits.
- Start 0, data 0xFF, stop 0 -> frame_err pulse, o keeps 0xA5, o_valid stays 0.
- Reset=0 after 4 data bits, then a full frame for 0x3C -> o=0x3C, no residue from the aborted frame.
- With SHIFT_DESER_PARITY_EN: 0x01 with parity 1 -> o=0x01, o_valid. 0x01 with parity 0 -> frame_err, o unchanged.

Source files
------------

// File: rtl/shift_deserializer_pkg.sv
// Shared types and constants for the shift-register serial link blocks.
package shift_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2,
        PARITY = 2'd3
    } state_e;

    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Enabled bit counter with synchronous clear; tc_o flags the last bit
// (count == WIDTH-1) and the counter wraps to 0 when it advances past it.
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && tc_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Framed serial-to-parallel receiver, state on the falling clock edge.
// Define SHIFT_DESER_PARITY_EN to add an even-parity bit after the data.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sen,
    input  logic             dir,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             frame_err,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             dir_q, dir_d;
    logic             ov_q, ov_d;
    logic             fe_q, fe_d;
    logic             par_bad;
    logic             last_bit;

`ifdef SHIFT_DESER_PARITY_EN
    logic perr_q, perr_d;
    assign par_bad = perr_q;
`else
    assign par_bad = 1'b0;
`endif

    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (sen && (state_q == DATA)),
        .clr_i (state_q != DATA),
        .tc_o  (last_bit)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        o_d     = o_q;
        dir_d   = dir_q;
        ov_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sen && (sin != IDLE_LEVEL)) begin
                    state_d = DATA;
                    dir_d   = dir;
                end
            end
            DATA: begin
                if (sen) begin
                    if (dir_q == DIR_MSB_FIRST) begin
                        sr_d = {sr_q[WIDTH-2:0], sin};
                    end else begin
                        sr_d = {sin, sr_q[WIDTH-1:1]};
                    end
                    if (last_bit) begin
`ifdef SHIFT_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SHIFT_DESER_PARITY_EN
            PARITY: begin
                if (sen) begin
                    perr_d  = (sin != ^sr_q);
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (sen) begin
                    state_d = IDLE;
                    // A bad parity bit is reported as a framing error too.
                    if ((sin == IDLE_LEVEL) && !par_bad) begin
                        o_d  = sr_q;
                        ov_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            o_q     <= '0;
            dir_q   <= DIR_LSB_FIRST;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            o_q     <= o_d;
            dir_q   <= dir_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    always_ff @(negedge clk) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    assign o         = o_q;
    assign o_valid   = ov_q;
    assign frame_err = fe_q;
    assign busy      = (state_q != IDLE);

endmodule
